// File: rtl/conv_pkg.sv
// Shared definitions for the 1-D convolution engine: FSM states, memory map and cfg bits.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StMac,
    StWrite,
    StDone
  } conv_state_e;

  localparam int unsigned AddrK      = 0;
  localparam int unsigned AddrN      = 1;
  localparam int unsigned AddrCfg    = 2;
  localparam int unsigned AddrKernel = 3;

  localparam int unsigned CfgStride2  = 0;
  localparam int unsigned CfgSaturate = 1;
  localparam int unsigned CfgRelu     = 2;

endpackage

// File: rtl/conv_out_fifo.sv
// Result FIFO with first-word fall-through head and circular pointers.
module conv_out_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic                         head_valid,
  output logic                         full,
  output logic [$clog2(OUT_DEPTH):0]   count
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] store [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full       = (count_q == CNT_W'(OUT_DEPTH));
  assign head_valid = (count_q != '0);
  assign head_data  = store[rd_ptr_q];
  assign count      = count_q;
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv1d_stream_engine.sv
// Valid-mode 1-D convolution over a shared memory image, one tap per cycle,
// results streamed through an output FIFO.
module conv1d_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_TAPS    = 16,
  parameter int unsigned BUFFER_SIZE = 64,
  parameter int unsigned OUT_DEPTH   = 16,
  parameter int unsigned OUT_SHIFT   = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             mem_wr_en,
  input  logic [$clog2(BUFFER_SIZE)-1:0]   mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]            mem_wr_data,
  input  logic                             start_conv,
  output logic                             busy,
  output logic                             conv_done,
  output logic                             conv_err,
  output logic                             conv_valid_led,
  output logic [DATA_WIDTH-1:0]            y_out,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_read_en,
  output logic [$clog2(OUT_DEPTH):0]       out_count
);

  localparam int unsigned ADDR_W = $clog2(BUFFER_SIZE);
  localparam int unsigned ACC_W  = 2 * DATA_WIDTH + $clog2(MAX_TAPS);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [ACC_W-1:0] SatMax =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

  conv_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       k_q, k_d, last_tap_q, last_tap_d, last_idx_q, last_idx_d;
  logic [ADDR_W-1:0]       tap_q, tap_d, idx_q, idx_d;
  logic                    stride2_q, stride2_d, sat_q, sat_d, relu_q, relu_d;
  logic                    err_q, err_d, led_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, shifted;
  logic [DATA_WIDTH-1:0]   y_q, result, coef, samp;
  logic [ADDR_W-1:0]       step, coef_addr, samp_addr;
  logic signed [PROD_W-1:0] coef_ext, samp_ext, prod;
  logic [31:0]             cfg_k, cfg_n, cfg_last_idx;
  logic [DATA_WIDTH-1:0]   cfg_word;
  logic                    cfg_bad, push, fifo_full;

  always_ff @(posedge clk) begin
    if (mem_wr_en && !busy && (32'(mem_wr_addr) < BUFFER_SIZE)) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  assign cfg_k    = 32'(mem[ADDR_W'(AddrK)]);
  assign cfg_n    = 32'(mem[ADDR_W'(AddrN)]);
  assign cfg_word = mem[ADDR_W'(AddrCfg)];
  assign cfg_bad  = (cfg_k == 0) || (cfg_k > MAX_TAPS) || (cfg_n < cfg_k) ||
                    (AddrKernel + cfg_k + cfg_n > BUFFER_SIZE);
  // Index of the last output: (N-K)/stride.
  assign cfg_last_idx = cfg_word[CfgStride2] ? ((cfg_n - cfg_k) >> 1) : (cfg_n - cfg_k);

  // Tap j of output i reads k[j] and x[s*i + K-1-j]; modular ADDR_W math is exact here.
  assign step      = stride2_q ? {idx_q[ADDR_W-2:0], 1'b0} : idx_q;
  assign coef_addr = ADDR_W'(AddrKernel) + tap_q;
  assign samp_addr = ADDR_W'(AddrKernel) + k_q + step + k_q - tap_q - ADDR_W'(1);
  assign coef      = mem[coef_addr];
  assign samp      = mem[samp_addr];
  assign coef_ext  = {{DATA_WIDTH{coef[DATA_WIDTH-1]}}, coef};
  assign samp_ext  = {{DATA_WIDTH{samp[DATA_WIDTH-1]}}, samp};
  assign prod      = coef_ext * samp_ext;

  always_comb begin
    shifted = acc_q >>> OUT_SHIFT;
    if (relu_q && shifted[ACC_W-1]) begin
      shifted = '0;
    end
    if (sat_q && (shifted > SatMax)) begin
      result = SatMax[DATA_WIDTH-1:0];
    end else if (sat_q && (shifted < SatMin)) begin
      result = SatMin[DATA_WIDTH-1:0];
    end else begin
      result = shifted[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_conv) state_d = StCheck;
      StCheck: state_d = cfg_bad ? StDone : StMac;
      StMac:   if (tap_q == last_tap_q) state_d = StWrite;
      StWrite: if (!fifo_full) state_d = (idx_q == last_idx_q) ? StDone : StMac;
      StDone:  if (start_conv) state_d = StCheck;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    conv_done = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      StCheck, StMac: busy = 1'b1;
      StWrite: begin
        busy = 1'b1;
        push = !fifo_full;
      end
      StDone:  conv_done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    k_d        = k_q;
    last_tap_d = last_tap_q;
    last_idx_d = last_idx_q;
    tap_d      = tap_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    stride2_d  = stride2_q;
    sat_d      = sat_q;
    relu_d     = relu_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle, StDone: if (start_conv) err_d = 1'b0;
      StCheck: begin
        err_d      = cfg_bad;
        k_d        = ADDR_W'(cfg_k);
        last_tap_d = ADDR_W'(cfg_k - 32'd1);
        last_idx_d = ADDR_W'(cfg_last_idx);
        stride2_d  = cfg_word[CfgStride2];
        sat_d      = cfg_word[CfgSaturate];
        relu_d     = cfg_word[CfgRelu];
        tap_d      = '0;
        idx_d      = '0;
        acc_d      = '0;
      end
      StMac: begin
        acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        tap_d = (tap_q == last_tap_q) ? '0 : tap_q + ADDR_W'(1);
      end
      StWrite: begin
        if (push) begin
          idx_d = idx_q + ADDR_W'(1);
          acc_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q        <= '0;
      last_tap_q <= '0;
      last_idx_q <= '0;
      tap_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      stride2_q  <= 1'b0;
      sat_q      <= 1'b0;
      relu_q     <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= 1'b0;
      y_q        <= '0;
    end else begin
      k_q        <= k_d;
      last_tap_q <= last_tap_d;
      last_idx_q <= last_idx_d;
      tap_q      <= tap_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      stride2_q  <= stride2_d;
      sat_q      <= sat_d;
      relu_q     <= relu_d;
      err_q      <= err_d;
      led_q      <= push;
      if (push) begin
        y_q <= result;
      end
    end
  end

  assign conv_err       = err_q;
  assign conv_valid_led = led_q;
  assign y_out          = y_q;

  conv_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (result),
    .pop       (out_read_en),
    .head_data (out_data),
    .head_valid(out_valid),
    .full      (fifo_full),
    .count     (out_count)
  );

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Directed bench for conv1d_stream_engine with a 2-entry output FIFO.
module tb_conv1d_stream_engine;

  logic       clk;
  logic       reset;
  logic       mem_wr_en;
  logic [5:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       start_conv;
  logic       busy, conv_done, conv_err, conv_valid_led;
  logic [7:0] y_out, out_data;
  logic       out_valid, out_read_en;
  logic [1:0] out_count;

  int compared;
  int fails;
  int kern_q[$];
  int x_q[$];
  int exp_q[$];
  logic [7:0] got_q[$];
  int led_n, led_first, led_second;

  conv1d_stream_engine #(
    .DATA_WIDTH (8),
    .MAX_TAPS   (16),
    .BUFFER_SIZE(64),
    .OUT_DEPTH  (2),
    .OUT_SHIFT  (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_wr_en     (mem_wr_en),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .start_conv    (start_conv),
    .busy          (busy),
    .conv_done     (conv_done),
    .conv_err      (conv_err),
    .conv_valid_led(conv_valid_led),
    .y_out         (y_out),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_read_en   (out_read_en),
    .out_count     (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wr(input int a, input int d);
    mem_wr_en   = 1'b1;
    mem_wr_addr = 6'(a);
    mem_wr_data = 8'(d);
    @(posedge clk); #1;
    mem_wr_en   = 1'b0;
  endtask

  task automatic load_image(input int k, input int n, input int cfg);
    wr(0, k);
    wr(1, n);
    wr(2, cfg);
    for (int i = 0; i < kern_q.size(); i++) wr(3 + i, kern_q[i]);
    for (int i = 0; i < x_q.size(); i++) wr(3 + kern_q.size() + i, x_q[i]);
  endtask

  task automatic start_pulse();
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
  endtask

  // Pops whatever appears while the run finishes; cycle 0 is the start edge.
  task automatic collect(input int max_cycles, input string tag);
    int c;
    got_q.delete();
    led_n = 0; led_first = -1; led_second = -1;
    c = 0;
    while (!(conv_done && !out_valid) && c < max_cycles) begin
      if (out_valid && out_read_en) got_q.push_back(out_data);
      @(posedge clk); #1;
      c++;
      if (conv_valid_led) begin
        if (led_n == 0) led_first = c;
        else if (led_n == 1) led_second = c;
        led_n++;
      end
    end
    compared++;
    if (!(conv_done && !out_valid)) begin
      fails++;
      $display("FAIL %s_timeout: done=%0b valid=%0b after %0d cycles, want done=1 valid=0",
               tag, conv_done, out_valid, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({busy, conv_done, conv_err, conv_valid_led, out_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000", {busy, conv_done, conv_err,
               conv_valid_led, out_valid});
    end
    compared++;
    if (y_out !== 8'd0) begin
      fails++; $display("FAIL reset_y_out: got %0d want 0", y_out);
    end
    compared++;
    if (out_count !== 2'd0) begin
      fails++; $display("FAIL reset_out_count: got %0d want 0", out_count);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] e;
    kern_q = '{2, 3, 4};
    x_q    = '{1, 2, 3, 4, 5, 6, 7};
    exp_q  = '{16, 25, 34, 43, 52};
    load_image(3, 7, 0);
    out_read_en = 1'b1;
    start_pulse();
    collect(200, "basic");
    compared++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = 8'(exp_q[i]);
      compared++;
      if (got_q[i] !== e) begin
        fails++; $display("FAIL basic_y%0d: got %0d want %0d", i, got_q[i], e);
      end
    end
    compared++;
    if (conv_err !== 1'b0) begin
      fails++; $display("FAIL basic_err: got %0b want 0", conv_err);
    end
    compared++;
    if (led_first != 5) begin
      fails++; $display("FAIL basic_first_latency: got %0d want 5", led_first);
    end
    compared++;
    if (led_second - led_first != 4) begin
      fails++; $display("FAIL basic_result_gap: got %0d want 4", led_second - led_first);
    end
    compared++;
    if (y_out !== 8'd52) begin
      fails++; $display("FAIL basic_y_out: got %0d want 52", y_out);
    end
  endtask

  task automatic test_stride2();
    logic [7:0] e;
    exp_q = '{16, 34, 52};
    wr(2, 1);
    start_pulse();
    collect(200, "stride2");
    compared++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL stride2_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = 8'(exp_q[i]);
      compared++;
      if (got_q[i] !== e) begin
        fails++; $display("FAIL stride2_y%0d: got %0d want %0d", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_saturate();
    kern_q = '{100};
    x_q    = '{100};
    load_image(1, 1, 2);
    start_pulse();
    collect(50, "sat_k1");
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 8'd127) begin
      fails++; $display("FAIL sat_k1: got %0d results, first %0d, want 1 result 127",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'd0);
    end
    kern_q = '{100, 100};
    x_q    = '{100, 100};
    load_image(2, 2, 2);
    start_pulse();
    collect(50, "sat_k2");
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 8'd127) begin
      fails++; $display("FAIL sat_k2: got %0d results, first %0d, want 1 result 127",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'd0);
    end
    wr(2, 0);
    start_pulse();
    collect(50, "wrap_k2");
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 8'd32) begin
      fails++; $display("FAIL wrap_k2: got %0d results, first %0d, want 1 result 32",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'd0);
    end
  endtask

  task automatic test_relu();
    kern_q = '{-1};
    x_q    = '{5, -3};
    load_image(1, 2, 4);
    start_pulse();
    collect(50, "relu");
    compared++;
    if (got_q.size() != 2) begin
      fails++; $display("FAIL relu_count: got %0d want 2", got_q.size());
    end else begin
      compared++;
      if (got_q[0] !== 8'd0) begin
        fails++; $display("FAIL relu_y0: got %0d want 0", got_q[0]);
      end
      compared++;
      if (got_q[1] !== 8'd3) begin
        fails++; $display("FAIL relu_y1: got %0d want 3", got_q[1]);
      end
    end
  endtask

  task automatic test_config_error();
    wr(0, 0);
    start_pulse();
    collect(20, "err_k0");
    compared++;
    if (conv_err !== 1'b1 || conv_done !== 1'b1) begin
      fails++; $display("FAIL err_k0_flags: got done=%0b err=%0b want 1 1", conv_done, conv_err);
    end
    compared++;
    if (led_n != 0 || got_q.size() != 0 || out_count !== 2'd0) begin
      fails++; $display("FAIL err_k0_pushes: got %0d pulses %0d pops want 0 0",
                        led_n, got_q.size());
    end
    wr(0, 3);
    wr(1, 2);
    start_pulse();
    collect(20, "err_n_lt_k");
    compared++;
    if (conv_err !== 1'b1 || led_n != 0) begin
      fails++; $display("FAIL err_n_lt_k: got err=%0b pulses=%0d want 1 0", conv_err, led_n);
    end
  endtask

  task automatic test_backpressure();
    int stall_leds;
    logic [7:0] e;
    kern_q = '{2, 3, 4};
    x_q    = '{1, 2, 3, 4, 5, 6, 7};
    exp_q  = '{16, 25, 34, 43, 52};
    load_image(3, 7, 0);
    out_read_en = 1'b0;
    start_pulse();
    stall_leds = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (conv_valid_led) stall_leds++;
    end
    compared++;
    if (stall_leds != 2) begin
      fails++; $display("FAIL bp_pulses_while_full: got %0d want 2", stall_leds);
    end
    compared++;
    if (busy !== 1'b1 || conv_done !== 1'b0 || conv_err !== 1'b0) begin
      fails++; $display("FAIL bp_held: got busy=%0b done=%0b err=%0b want 1 0 0",
                        busy, conv_done, conv_err);
    end
    compared++;
    if (out_count !== 2'd2) begin
      fails++; $display("FAIL bp_count: got %0d want 2", out_count);
    end
    wr(3, 0);  // must be dropped: engine is busy
    out_read_en = 1'b1;
    collect(200, "bp_drain");
    compared++;
    if (got_q.size() != exp_q.size() || stall_leds + led_n != 5) begin
      fails++; $display("FAIL bp_drain_count: got %0d pops %0d pulses want 5 5",
                        got_q.size(), stall_leds + led_n);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e = 8'(exp_q[i]);
      compared++;
      if (got_q[i] !== e) begin
        fails++; $display("FAIL bp_y%0d: got %0d want %0d", i, got_q[i], e);
      end
    end
    @(posedge clk); #1;
    compared++;
    if (out_count !== 2'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_pop_empty: got count=%0d valid=%0b want 0 0",
                        out_count, out_valid);
    end
  endtask

  task automatic test_reset_mid_mac();
    start_pulse();
    @(posedge clk); #1;
    compared++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL mid_busy_before_reset: got %0b want 1", busy);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({busy, conv_done, conv_err, conv_valid_led, out_valid} !== 5'b0 ||
        y_out !== 8'd0 || out_count !== 2'd0) begin
      fails++; $display("FAIL mid_reset_outputs: got flags=%b y=%0d count=%0d want 0 0 0",
                        {busy, conv_done, conv_err, conv_valid_led, out_valid}, y_out, out_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    compared++;
    if (busy !== 1'b0 || conv_done !== 1'b0) begin
      fails++; $display("FAIL mid_idle: got busy=%0b done=%0b want 0 0", busy, conv_done);
    end
    start_pulse();
    collect(200, "mid_rerun");
    compared++;
    if (got_q.size() != 5) begin
      fails++; $display("FAIL mid_rerun_count: got %0d want 5", got_q.size());
    end else begin
      compared++;
      if (got_q[0] !== 8'd16 || got_q[4] !== 8'd52) begin
        fails++; $display("FAIL mid_rerun_values: got %0d,%0d want 16,52", got_q[0], got_q[4]);
      end
    end
  endtask

  initial begin
    compared    = 0;
    fails       = 0;
    reset       = 1'b1;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    start_conv  = 1'b0;
    out_read_en = 1'b0;
    test_reset();
    test_basic();
    test_stride2();
    test_saturate();
    test_relu();
    test_config_error();
    test_backpressure();
    test_reset_mid_mac();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule

// File: doc/conv1d_stream_engine.md
CONV1D_STREAM_ENGINE -- requirements
Module: conv1d_stream_engine

Interface
REQ-001 SHALL take parameters: DATA_WIDTH, default 8, sample/coefficient/result width (signed two's complement); MAX_TAPS, default 16, maximum kernel length; BUFFER_SIZE, default 64, shared memory words; OUT_DEPTH, default 16, output FIFO entries; OUT_SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-002 SHALL derive ADDR_W = clog2(BUFFER_SIZE) and ACC_W = 2*DATA_WIDTH + clog2(MAX_TAPS).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide these ports:
 clk  in  1  rising-edge clock
 reset  in  1  asynchronous active-high reset
 mem_wr_en  in  1  write strobe into shared memory
 mem_wr_addr  in  ADDR_W  write address
 mem_wr_data  in  DATA_WIDTH  write data
 start_conv  in  1  start request, sampled in IDLE/DONE
 busy  out  1  high in CHECK/MAC/WRITE
 conv_done  out  1  level, high in DONE
 conv_err  out  1  configuration error, valid with conv_done
 conv_valid_led  out  1  one-cycle pulse per result pushed
 y_out  out  DATA_WIDTH  last pushed result
 out_data  out  DATA_WIDTH  FIFO head (first-word fall-through)
 out_valid  out  1  FIFO non-empty
 out_read_en  in  1  pop FIFO head
 out_count  out  clog2(OUT_DEPTH)+1  FIFO occupancy

Function
REQ-005 SHALL use this memory map: mem[0]=K (tap count), mem[1]=N (sample count), mem[2]=cfg (bit0 stride2, bit1 saturate else wrap, bit2 ReLU), mem[3..3+K-1]=kernel k[0..K-1], mem[3+K..3+K+N-1]=samples x[0..N-1]; K and N unsigned.
REQ-006 SHALL ignore mem_wr_en while busy; out-of-range addresses are dropped.
REQ-007 SHALL compute valid-mode convolution y[i] = sum over j of k[j]*x[s*i+K-1-j], with s=1 or 2, for i=0..M-1, where M=N-K+1 (stride1) or floor((N-K)/2)+1 (stride2).
REQ-008 SHALL implement FSM IDLE -> CHECK on start_conv; CHECK -> DONE with conv_err=1 if K=0, K>MAX_TAPS, N<K or 3+K+N>BUFFER_SIZE, else CHECK -> MAC; MAC lasts exactly K cycles (one tap per cycle, ACC_W accumulator cleared on entry); MAC -> WRITE; WRITE -> MAC (next i) or DONE after the M-th push; DONE -> CHECK on start_conv (conv_done and conv_err clear).
REQ-009 SHALL ignore start_conv while busy.
REQ-010 SHALL form the result as acc >>> OUT_SHIFT, then apply ReLU (negative -> 0) if enabled, then either saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] or keep the low DATA_WIDTH bits.
REQ-011 SHALL, in WRITE, push the result, update y_out and pulse conv_valid_led in the same cycle when the FIFO is not full at that edge; when it is full, it SHALL hold WRITE (backpressure) with no pulse.
REQ-012 SHALL pop when out_read_en and out_valid are both high; out_read_en on an empty FIFO is ignored; simultaneous pop and push updates out_count by zero.
REQ-013 SHALL produce the first result with start_conv sampled at edge t0: push at edge t0+K+2; each subsequent result K+1 cycles later, absent stalls.

Reset
REQ-014 SHALL, on reset, force the FSM to IDLE and drive busy, conv_done, conv_err, conv_valid_led, y_out, out_valid and out_count to 0, emptying the FIFO, including mid-operation; shared memory contents are not cleared.

Structure
REQ-015 SHALL place the FSM state enum, memory-map offsets (K, N, cfg, kernel base) and cfg bit indices in the shared package conv_pkg.
REQ-016 SHALL implement the output FIFO as sub-module conv_out_fifo (parameters DATA_WIDTH, OUT_DEPTH), with circular pointers wrapping at OUT_DEPTH.

Verification
REQ-017 Bench SHALL cover: K=3, k=[2,3,4], N=7, x=1..7, cfg=0 -> pops 16,25,34,43,52, conv_err=0.
REQ-018 Bench SHALL cover: the same data with cfg=1 (stride2) -> 16,34,52.
REQ-019 Bench SHALL cover: K=1, k=[100], wait, K=2, k=[100,100], x=[100,100], DATA_WIDTH=8 -> cfg=2 gives 127; cfg=0 gives 32.
REQ-020 Bench SHALL cover: K=1, k=[-1], x=[5,-3], cfg=4 -> 0,3.
REQ-021 Bench SHALL cover: OUT_DEPTH=2 with no reads, then draining -> busy is held in WRITE, no conv_valid_led pulse while full, and all 5 results are eventually popped in order.
REQ-022 Bench SHALL cover: K=0 -> conv_done with conv_err=1 and no pushes; reset asserted during MAC -> all outputs 0 and the FSM in IDLE.
